// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
package ahb_apb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [DATA_W-1:0] APB_ERR_DATA = 32'hbad1_bad1;

    // Address-phase command held for the duration of one APB transfer
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
    } ahb_cmd_t;

endpackage

// File: rtl/ahb_to_apb_bridge_if.sv
// AHB-Lite slave side and APB master side signals of the bridge.
interface ahb_to_apb_bridge_if #(
    parameter int unsigned NUM_SLAVES = 4
);
    import ahb_apb_pkg::*;

    logic                         HSEL;
    logic [ADDR_W-1:0]            HADDR;
    logic [1:0]                   HTRANS;
    logic                         HWRITE;
    logic [2:0]                   HSIZE;
    logic [DATA_W-1:0]            HWDATA;
    logic                         HREADY;
    logic                         HREADYOUT;
    logic [DATA_W-1:0]            HRDATA;
    logic                         HRESP;
    logic [ADDR_W-1:0]            PADDR;
    logic [DATA_W-1:0]            PWDATA;
    logic                         PWRITE;
    logic                         PENABLE;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    // Bridge view
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, PRDATA, PSLVERR,
        output HREADYOUT, HRDATA, HRESP, PADDR, PWDATA, PWRITE, PENABLE, PSEL
    );

    // AHB master plus APB peripherals view
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, PRDATA, PSLVERR,
        input  HREADYOUT, HRDATA, HRESP, PADDR, PWDATA, PWRITE, PENABLE, PSEL
    );

endinterface

// File: rtl/apb_slave_decode.sv
// Address-phase decode: peripheral index, transfer-valid and illegal-transfer flags.
module apb_slave_decode
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES    = 4,
    parameter int unsigned SLAVE_SEL_LSB = 12,
    parameter int unsigned IDX_W         = 2
) (
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [2:0]        i_hsize,
    input  logic [1:0]        i_htrans,
    output logic [IDX_W-1:0]  o_idx_c,
    output logic              o_valid_c,
    output logic              o_err_c
);

    localparam int unsigned CMP_W = IDX_W + 1;

    logic w_idx_oob;
    logic w_unused_bits;

    assign o_idx_c   = i_haddr[SLAVE_SEL_LSB +: IDX_W];
    assign w_idx_oob = {1'b0, o_idx_c} >= CMP_W'(NUM_SLAVES);
    assign o_valid_c = i_htrans[1];
    // Only aligned word transfers to an existing peripheral reach the APB
    assign o_err_c   = w_idx_oob | (i_hsize != HSIZE_WORD) | (i_haddr[1:0] != 2'b00);

    assign w_unused_bits = ^{i_haddr[ADDR_W-1:SLAVE_SEL_LSB+IDX_W],
                             i_haddr[SLAVE_SEL_LSB-1:2], i_htrans[0]};

endmodule

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one setup+access pair per AHB word transfer,
// with AHB wait states until the APB side completes.
module ahb_to_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES    = 4,
    parameter int unsigned SLAVE_SEL_LSB = 12,
    parameter int unsigned IDX_W         = 2
) (
    input logic                clk,
    input logic                n_rst,
    ahb_to_apb_bridge_if.slave bus
);

    logic [IDX_W-1:0]      w_dec_idx;
    logic                  w_dec_valid;
    logic                  w_dec_err;
    logic                  w_xfer;
    logic [DATA_W-1:0]     w_sel_rdata;
    logic                  w_sel_slverr;

    state_e                r_state,     w_state_nxt;
    ahb_cmd_t              r_cmd,       w_cmd_nxt;
    logic [IDX_W-1:0]      r_idx,       w_idx_nxt;
    logic                  r_hreadyout, w_hreadyout_nxt;
    logic                  r_hresp,     w_hresp_nxt;
    logic [DATA_W-1:0]     r_hrdata,    w_hrdata_nxt;
    logic [ADDR_W-1:0]     r_paddr,     w_paddr_nxt;
    logic [DATA_W-1:0]     r_pwdata,    w_pwdata_nxt;
    logic                  r_pwrite,    w_pwrite_nxt;
    logic                  r_penable,   w_penable_nxt;
    logic [NUM_SLAVES-1:0] r_psel,      w_psel_nxt;

    apb_slave_decode #(
        .NUM_SLAVES    (NUM_SLAVES),
        .SLAVE_SEL_LSB (SLAVE_SEL_LSB),
        .IDX_W         (IDX_W)
    ) u_decode (
        .i_haddr   (bus.HADDR),
        .i_hsize   (bus.HSIZE),
        .i_htrans  (bus.HTRANS),
        .o_idx_c   (w_dec_idx),
        .o_valid_c (w_dec_valid),
        .o_err_c   (w_dec_err)
    );

    assign w_xfer = bus.HSEL & w_dec_valid & bus.HREADY;

    // Read data and error flag of the peripheral being accessed
    always_comb begin : apb_resp_mux
        w_sel_rdata  = '0;
        w_sel_slverr = 1'b0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel_rdata  = bus.PRDATA[k*DATA_W +: DATA_W];
                w_sel_slverr = bus.PSLVERR[k];
            end
        end
    end

    always_comb begin : next_state_logic
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_idx_nxt       = r_idx;
        w_hrdata_nxt    = r_hrdata;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pwrite_nxt    = r_pwrite;
        w_hreadyout_nxt = 1'b1;
        w_hresp_nxt     = HRESP_OKAY;
        w_penable_nxt   = 1'b0;
        w_psel_nxt      = '0;

        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (w_xfer) begin
                    w_cmd_nxt = '{addr: bus.HADDR, write: bus.HWRITE};
                    w_idx_nxt = w_dec_idx;
                    if (w_dec_err)        w_state_nxt = S_ERR1;
                    else if (bus.HWRITE)  w_state_nxt = S_WDATA;
                    else                  w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WDATA: begin
                w_pwdata_nxt = bus.HWDATA;
                w_state_nxt  = S_SETUP;
            end
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (w_sel_slverr) begin
                    w_hrdata_nxt = APB_ERR_DATA;
                    w_state_nxt  = S_ERR1;
                end else begin
                    w_hrdata_nxt = r_cmd.write ? '0 : w_sel_rdata;
                    w_state_nxt  = S_DONE;
                end
            end
            S_ERR1:   w_state_nxt = S_ERR2;
            default:  w_state_nxt = S_IDLE;
        endcase

        // Registered outputs follow the state being entered
        case (w_state_nxt)
            S_WDATA: w_hreadyout_nxt = 1'b0;
            S_SETUP, S_ACCESS: begin
                w_hreadyout_nxt = 1'b0;
                w_penable_nxt   = (w_state_nxt == S_ACCESS);
                w_paddr_nxt     = w_cmd_nxt.addr;
                w_pwrite_nxt    = w_cmd_nxt.write;
                for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
                    w_psel_nxt[k] = (w_idx_nxt == IDX_W'(k));
                end
            end
            S_ERR1: begin
                w_hreadyout_nxt = 1'b0;
                w_hresp_nxt     = HRESP_ERROR;
            end
            S_ERR2:  w_hresp_nxt = HRESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin : state_reg
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_idx       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_hrdata    <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_psel      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_idx       <= w_idx_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
            r_hrdata    <= w_hrdata_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_penable   <= w_penable_nxt;
            r_psel      <= w_psel_nxt;
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = r_hrdata;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PENABLE   = r_penable;
    assign bus.PSEL      = r_psel;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Bench for ahb_to_apb_bridge: directed scenarios plus randomized transfers against
// a transaction-level model of latency, APB selection and AHB response.
module tb_ahb_to_apb_bridge;
    import ahb_apb_pkg::*;

    localparam int unsigned NS  = 4;
    localparam int unsigned IW  = 3;   // 3-bit index so 0x4000 decodes to peripheral 4 (absent)
    localparam int unsigned LSB = 12;

    typedef struct {
        int            waits;
        int            psel_cnt;
        int            multi;
        int            pen_cnt;
        logic [NS-1:0] psel_or;
        logic [NS-1:0] first_psel;
        logic [NS-1:0] last_psel;
        logic [NS-1:0] pen_psel;
        logic          first_pen;
        logic [31:0]   pen_paddr;
        logic [31:0]   pen_pwdata;
        logic          pen_pwrite;
        logic          wait_hresp;
        logic          hresp;
        logic [31:0]   hrdata;
    } res_t;

    logic        clk   = 1'b0;
    logic        n_rst = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hrdata = '0;
    logic [31:0] prd [NS];
    logic [NS-1:0] serr_v;

    always #5 clk = ~clk;

    ahb_to_apb_bridge_if #(.NUM_SLAVES(NS)) bif ();
    assign bif.HREADY = bif.HREADYOUT;

    ahb_to_apb_bridge #(
        .NUM_SLAVES    (NS),
        .SLAVE_SEL_LSB (LSB),
        .IDX_W         (IW)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bif)
    );

    task automatic load_periph(input int err_pct);
        for (int k = 0; k < NS; k++) begin
            prd[k]    = $urandom;
            serr_v[k] = ($urandom_range(99) < err_pct);
            bif.PRDATA[k*32 +: 32] = prd[k];
        end
        bif.PSLVERR = serr_v;
    endtask

    // Transaction-level expectation: each legal word transfer is one 2-cycle APB
    // access, writes add one data-phase cycle, errors add one ERROR cycle.
    function automatic res_t model(input logic [31:0] addr, input logic wr,
                                   input logic [2:0] size, input logic [31:0] wdata);
        res_t e;
        int   idx;
        bit   derr, serr;
        e    = '{default: 0};
        idx  = int'(addr >> LSB) % 8;
        derr = (idx >= NS) || (size != 3'd2) || (addr % 4 != 0);
        serr = 1'b0;
        if (!derr) serr = serr_v[idx];
        e.waits      = derr ? 1 : ((wr ? 3 : 2) + (serr ? 1 : 0));
        e.psel_cnt   = derr ? 0 : 2;
        e.pen_cnt    = derr ? 0 : 1;
        e.psel_or    = derr ? '0 : NS'(1 << idx);
        e.hresp      = derr || serr;
        e.wait_hresp = e.hresp;
        e.pen_paddr  = addr;
        e.pen_pwrite = wr;
        e.pen_pwdata = wdata;
        if (derr)      e.hrdata = m_hrdata;
        else if (serr) e.hrdata = 32'hbad1_bad1;
        else if (wr)   e.hrdata = 32'h0;
        else           e.hrdata = prd[idx];
        return e;
    endfunction

    // Must be called at a negedge of a cycle where HREADYOUT=1; returns at the
    // negedge of the cycle that completes the transfer.
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, output res_t r);
        r = '{default: 0};
        bif.HSEL   = 1'b1;
        bif.HTRANS = HTRANS_NONSEQ;
        bif.HADDR  = addr;
        bif.HWRITE = wr;
        bif.HSIZE  = size;
        @(posedge clk);
        @(negedge clk);
        bif.HSEL   = 1'b0;
        bif.HTRANS = HTRANS_IDLE;
        bif.HWDATA = wdata;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) begin
                r.first_psel = bif.PSEL;
                r.first_pen  = bif.PENABLE;
            end
            if (bif.PSEL != '0) r.psel_cnt++;
            if ($countones(bif.PSEL) > 1) r.multi++;
            r.psel_or |= bif.PSEL;
            if (bif.PENABLE) begin
                r.pen_cnt++;
                r.pen_psel   = bif.PSEL;
                r.pen_paddr  = bif.PADDR;
                r.pen_pwdata = bif.PWDATA;
                r.pen_pwrite = bif.PWRITE;
            end
            if (!bif.HREADYOUT) begin
                r.waits++;
                r.wait_hresp = bif.HRESP;
            end else begin
                r.hresp     = bif.HRESP;
                r.hrdata    = bif.HRDATA;
                r.last_psel = bif.PSEL;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bif.HSEL = 1'b0; bif.HADDR = '0; bif.HTRANS = HTRANS_IDLE; bif.HWRITE = 1'b0;
        bif.HSIZE = 3'd2; bif.HWDATA = '0; bif.PRDATA = '0; bif.PSLVERR = '0;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({bif.HREADYOUT, bif.HRESP} !== 2'b10) $display("FAIL reset_hready_hresp: got %b want 10", {bif.HREADYOUT, bif.HRESP}); else n_pass++;
        n_checks++; if (bif.HRDATA !== 32'h0) $display("FAIL reset_hrdata: got %h want 0", bif.HRDATA); else n_pass++;
        n_checks++; if ({bif.PSEL, bif.PENABLE, bif.PWRITE} !== '0) $display("FAIL reset_apb_ctrl: got %b want 0", {bif.PSEL, bif.PENABLE, bif.PWRITE}); else n_pass++;
        n_checks++; if ({bif.PADDR, bif.PWDATA} !== 64'h0) $display("FAIL reset_apb_data: got %h want 0", {bif.PADDR, bif.PWDATA}); else n_pass++;
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        res_t r, e;
        load_periph(0);
        prd[1] = 32'hCAFE_0001;
        bif.PRDATA[32 +: 32] = prd[1];
        e = model(32'h0000_1004, 1'b0, 3'd2, 32'h0);
        run_xfer(32'h0000_1004, 1'b0, 3'd2, 32'h0, r);
        m_hrdata = e.hrdata;
        n_checks++; if (r.first_psel !== 4'b0010) $display("FAIL read_setup_psel: got %b want 0010", r.first_psel); else n_pass++;
        n_checks++; if (r.first_pen !== 1'b0) $display("FAIL read_setup_penable: got %b want 0", r.first_pen); else n_pass++;
        n_checks++; if (r.pen_psel !== 4'b0010 || r.pen_cnt !== 1) $display("FAIL read_access: got psel %b cnt %0d want 0010 1", r.pen_psel, r.pen_cnt); else n_pass++;
        n_checks++; if (r.waits !== 2) $display("FAIL read_waits: got %0d want 2", r.waits); else n_pass++;
        n_checks++; if (r.hrdata !== 32'hCAFE_0001) $display("FAIL read_hrdata: got %h want cafe0001", r.hrdata); else n_pass++;
        n_checks++; if (r.hresp !== 1'b0) $display("FAIL read_hresp: got %b want 0", r.hresp); else n_pass++;
    endtask

    task automatic test_write();
        res_t r, e;
        @(negedge clk);
        load_periph(0);
        e = model(32'h0000_2008, 1'b1, 3'd2, 32'h1234_5678);
        run_xfer(32'h0000_2008, 1'b1, 3'd2, 32'h1234_5678, r);
        m_hrdata = e.hrdata;
        n_checks++; if (r.first_psel !== 4'b0000) $display("FAIL write_wdata_psel: got %b want 0000", r.first_psel); else n_pass++;
        n_checks++; if (r.psel_or !== 4'b0100 || r.psel_cnt !== 2) $display("FAIL write_psel: got %b x%0d want 0100 x2", r.psel_or, r.psel_cnt); else n_pass++;
        n_checks++; if (r.pen_pwdata !== 32'h1234_5678) $display("FAIL write_pwdata: got %h want 12345678", r.pen_pwdata); else n_pass++;
        n_checks++; if (r.pen_pwrite !== 1'b1 || r.pen_paddr !== 32'h0000_2008) $display("FAIL write_pwrite_paddr: got %b %h want 1 00002008", r.pen_pwrite, r.pen_paddr); else n_pass++;
        n_checks++; if (r.waits !== 3) $display("FAIL write_waits: got %0d want 3", r.waits); else n_pass++;
        n_checks++; if (r.hresp !== 1'b0) $display("FAIL write_hresp: got %b want 0", r.hresp); else n_pass++;
    endtask

    task automatic test_decode_error();
        res_t r, e;
        @(negedge clk);
        load_periph(0);
        e = model(32'h0000_4000, 1'b0, 3'd2, 32'h0);
        run_xfer(32'h0000_4000, 1'b0, 3'd2, 32'h0, r);
        m_hrdata = e.hrdata;
        n_checks++; if (r.psel_or !== 4'b0000) $display("FAIL decerr_psel: got %b want 0000", r.psel_or); else n_pass++;
        n_checks++; if (r.waits !== 1 || r.wait_hresp !== 1'b1) $display("FAIL decerr_err1: got waits %0d hresp %b want 1 1", r.waits, r.wait_hresp); else n_pass++;
        n_checks++; if (r.hresp !== 1'b1) $display("FAIL decerr_err2_hresp: got %b want 1", r.hresp); else n_pass++;
        n_checks++; if (r.hrdata !== e.hrdata) $display("FAIL decerr_hrdata: got %h want %h", r.hrdata, e.hrdata); else n_pass++;
    endtask

    task automatic test_slave_error();
        res_t r, e;
        @(negedge clk);
        load_periph(0);
        serr_v[0]   = 1'b1;
        bif.PSLVERR = serr_v;
        e = model(32'h0000_0010, 1'b0, 3'd2, 32'h0);
        run_xfer(32'h0000_0010, 1'b0, 3'd2, 32'h0, r);
        m_hrdata = e.hrdata;
        n_checks++; if (r.waits !== 3 || r.wait_hresp !== 1'b1) $display("FAIL slverr_err1: got waits %0d hresp %b want 3 1", r.waits, r.wait_hresp); else n_pass++;
        n_checks++; if (r.hresp !== 1'b1) $display("FAIL slverr_err2_hresp: got %b want 1", r.hresp); else n_pass++;
        n_checks++; if (r.hrdata !== 32'hbad1_bad1) $display("FAIL slverr_hrdata: got %h want bad1bad1", r.hrdata); else n_pass++;
        n_checks++; if (r.pen_cnt !== 1 || r.pen_psel !== 4'b0001) $display("FAIL slverr_access: got %0d %b want 1 0001", r.pen_cnt, r.pen_psel); else n_pass++;
        bif.PSLVERR = '0;
    endtask

    task automatic test_back_to_back();
        res_t r1, r2, e1, e2;
        @(negedge clk);
        load_periph(0);
        e1 = model(32'h0000_0000, 1'b0, 3'd2, 32'h0);
        run_xfer(32'h0000_0000, 1'b0, 3'd2, 32'h0, r1);
        m_hrdata = e1.hrdata;
        e2 = model(32'h0000_3000, 1'b0, 3'd2, 32'h0);
        run_xfer(32'h0000_3000, 1'b0, 3'd2, 32'h0, r2);
        m_hrdata = e2.hrdata;
        n_checks++; if (r1.psel_or !== 4'b0001) $display("FAIL b2b_first_psel: got %b want 0001", r1.psel_or); else n_pass++;
        n_checks++; if (r1.last_psel !== 4'b0000) $display("FAIL b2b_gap_psel: got %b want 0000", r1.last_psel); else n_pass++;
        n_checks++; if (r2.first_psel !== 4'b1000) $display("FAIL b2b_second_psel: got %b want 1000", r2.first_psel); else n_pass++;
        n_checks++; if ({r1.hresp, r2.hresp} !== 2'b00) $display("FAIL b2b_hresp: got %b want 00", {r1.hresp, r2.hresp}); else n_pass++;
        n_checks++; if (r1.hrdata !== e1.hrdata) $display("FAIL b2b_first_hrdata: got %h want %h", r1.hrdata, e1.hrdata); else n_pass++;
        n_checks++; if (r2.hrdata !== e2.hrdata || r2.waits !== 2) $display("FAIL b2b_second: got %h w%0d want %h w2", r2.hrdata, r2.waits, e2.hrdata); else n_pass++;
    endtask

    task automatic test_idle_busy();
        @(negedge clk);
        bif.HSEL = 1'b1; bif.HTRANS = HTRANS_BUSY; bif.HADDR = 32'h0000_1000; bif.HWRITE = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++; if ({bif.HREADYOUT, bif.HRESP, bif.PSEL, bif.PENABLE} !== 7'b1000000) $display("FAIL busy_zero_wait: got %b want 1000000", {bif.HREADYOUT, bif.HRESP, bif.PSEL, bif.PENABLE}); else n_pass++;
        bif.HSEL = 1'b0; bif.HTRANS = HTRANS_NONSEQ;
        @(posedge clk); @(negedge clk);
        n_checks++; if ({bif.HREADYOUT, bif.HRESP, bif.PSEL, bif.PENABLE} !== 7'b1000000) $display("FAIL unselected_zero_wait: got %b want 1000000", {bif.HREADYOUT, bif.HRESP, bif.PSEL, bif.PENABLE}); else n_pass++;
        bif.HTRANS = HTRANS_IDLE;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bif.HSEL = 1'b1; bif.HTRANS = HTRANS_NONSEQ; bif.HADDR = 32'h0000_1000;
        bif.HWRITE = 1'b0; bif.HSIZE = 3'd2;
        @(posedge clk); @(negedge clk);
        bif.HSEL = 1'b0; bif.HTRANS = HTRANS_IDLE;
        n_checks++; if (bif.PSEL !== 4'b0010) $display("FAIL rstmid_setup_psel: got %b want 0010", bif.PSEL); else n_pass++;
        n_rst = 1'b0;
        #1;
        m_hrdata = '0;
        n_checks++; if ({bif.PSEL, bif.PENABLE} !== 5'b0) $display("FAIL rstmid_apb_drop: got %b want 00000", {bif.PSEL, bif.PENABLE}); else n_pass++;
        n_checks++; if ({bif.HREADYOUT, bif.HRESP} !== 2'b10) $display("FAIL rstmid_hready: got %b want 10", {bif.HREADYOUT, bif.HRESP}); else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        bif.HSEL = 1'b1; bif.HTRANS = HTRANS_IDLE;
        @(posedge clk); @(negedge clk);
        n_checks++; if ({bif.HREADYOUT, bif.HRESP, bif.PSEL, bif.PENABLE} !== 7'b1000000) $display("FAIL rstmid_idle_okay: got %b want 1000000", {bif.HREADYOUT, bif.HRESP, bif.PSEL, bif.PENABLE}); else n_pass++;
        n_checks++; if (bif.HRDATA !== m_hrdata) $display("FAIL rstmid_hrdata: got %h want %h", bif.HRDATA, m_hrdata); else n_pass++;
        bif.HSEL = 1'b0;
    endtask

    task automatic test_random();
        res_t        r, e;
        logic [31:0] a, wd;
        logic [2:0]  sz;
        logic        wr;
        for (int n = 0; n < 40; n++) begin
            load_periph(20);
            a  = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 5)) << LSB) | (32'($urandom_range(0, 1023)) << 2);
            if ($urandom_range(9) == 0) a = a | 32'($urandom_range(1, 3));
            sz = ($urandom_range(9) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
            wr = 1'($urandom_range(1));
            wd = $urandom;
            e  = model(a, wr, sz, wd);
            run_xfer(a, wr, sz, wd, r);
            m_hrdata = e.hrdata;
            n_checks++; if (r.waits !== e.waits) $display("FAIL rnd%0d_waits: got %0d want %0d", n, r.waits, e.waits); else n_pass++;
            n_checks++; if (r.psel_or !== e.psel_or || r.psel_cnt !== e.psel_cnt || r.multi !== 0) $display("FAIL rnd%0d_psel: got %b x%0d multi %0d want %b x%0d", n, r.psel_or, r.psel_cnt, r.multi, e.psel_or, e.psel_cnt); else n_pass++;
            n_checks++; if (r.pen_cnt !== e.pen_cnt) $display("FAIL rnd%0d_penable: got %0d want %0d", n, r.pen_cnt, e.pen_cnt); else n_pass++;
            n_checks++; if ({r.wait_hresp, r.hresp} !== {e.wait_hresp, e.hresp}) $display("FAIL rnd%0d_hresp: got %b want %b", n, {r.wait_hresp, r.hresp}, {e.wait_hresp, e.hresp}); else n_pass++;
            n_checks++; if (r.hrdata !== e.hrdata) $display("FAIL rnd%0d_hrdata: got %h want %h", n, r.hrdata, e.hrdata); else n_pass++;
            n_checks++; if (r.last_psel !== '0) $display("FAIL rnd%0d_done_psel: got %b want 0", n, r.last_psel); else n_pass++;
            if (e.pen_cnt == 1) begin
                n_checks++; if (r.pen_paddr !== e.pen_paddr || r.pen_pwrite !== e.pen_pwrite) $display("FAIL rnd%0d_paddr_pwrite: got %h %b want %h %b", n, r.pen_paddr, r.pen_pwrite, e.pen_paddr, e.pen_pwrite); else n_pass++;
                if (wr) begin
                    n_checks++; if (r.pen_pwdata !== e.pen_pwdata) $display("FAIL rnd%0d_pwdata: got %h want %h", n, r.pen_pwdata, e.pen_pwdata); else n_pass++;
                end
            end
            if ($urandom_range(1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_decode_error();
        test_slave_error();
        test_back_to_back();
        test_idle_busy();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
